// File: rtl/sfm_pkg.sv
// ============================================================================
// Module      : sfm_pkg
// Description : Shared types and constants for the expu pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sfm_pkg;

    localparam int EXPU_CNT_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } expu_ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/expu_perf_cnt.sv
// ============================================================================
// Module      : expu_perf_cnt
// Description : Pair of saturating event counters (completed ops, stalls).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module expu_perf_cnt #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 op_inc_i,
    input  logic                 stall_inc_i,
    output logic [CNT_WIDTH-1:0] op_cnt_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
);

    logic [CNT_WIDTH-1:0] op_cnt_q, op_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        op_cnt_d    = op_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (clear_i) begin
            op_cnt_d    = '0;
            stall_cnt_d = '0;
        end else begin
            // Hold at all-ones instead of wrapping.
            if (op_inc_i && !(&op_cnt_q)) begin
                op_cnt_d = op_cnt_q + 1'b1;
            end
            if (stall_inc_i && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            op_cnt_q    <= op_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign op_cnt_o    = op_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

`default_nettype wire

// File: rtl/expu_pipe_ctrl.sv
// ============================================================================
// Module      : expu_pipe_ctrl
// Description : Valid/ready sequencer for a row of datapath register stages,
//               with drain (flush), soft clear and optional perf counters.
//               Counters are built only when EXPU_PIPE_CTRL_PERF_CNT_EN is
//               defined; otherwise they read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module expu_pipe_ctrl
    import sfm_pkg::*;
#(
    parameter int NUM_REGS  = 3,
    parameter int CNT_WIDTH = EXPU_CNT_WIDTH_DEFAULT,
    localparam int EN_W     = (NUM_REGS > 0) ? NUM_REGS : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    input  logic                 flush_i,
    output logic                 flush_done_o,
    output logic [EN_W-1:0]      enable_o,
    output logic                 clear_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] op_cnt_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
);

    expu_ctrl_state_e state_q, state_d;

    logic drain;
    logic accept;
    logic any_v;
    logic rdy_head;

    assign drain   = (state_q == DRAIN);
    assign ready_o = rdy_head & ~drain;
    assign accept  = valid_i & ready_o;

    generate
        if (NUM_REGS > 0) begin : g_stages
            logic [NUM_REGS-1:0] v_q, v_d, in_v;
            logic [NUM_REGS:0]   rdy;

            // A stage can take new data if it is empty or its occupant moves on.
            always_comb begin
                rdy           = '0;
                rdy[NUM_REGS] = ready_i;
                for (int i = NUM_REGS - 1; i >= 0; i--) begin
                    rdy[i] = ~v_q[i] | rdy[i+1];
                end
            end

            always_comb begin
                in_v    = '0;
                in_v[0] = accept;
                for (int i = 1; i < NUM_REGS; i++) begin
                    in_v[i] = v_q[i-1];
                end
                v_d = v_q;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (rdy[i]) begin
                        v_d[i] = in_v[i];
                    end
                end
                if (clear_i) begin
                    v_d = '0;
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    v_q <= '0;
                end else begin
                    v_q <= v_d;
                end
            end

            assign rdy_head = rdy[0];
            assign valid_o  = v_q[NUM_REGS-1];
            assign any_v    = |v_q;
            assign enable_o = in_v & rdy[NUM_REGS-1:0];
        end else begin : g_passthru
            assign rdy_head = ready_i;
            assign valid_o  = valid_i;
            assign any_v    = 1'b0;
            assign enable_o = '0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = DRAIN;
                end else if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_d = DRAIN;
                end else if (!any_v && !accept) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (!any_v) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A clear that lands on the final drain cycle aborts it silently.
    assign flush_done_o = drain & ~any_v & ~clear_i;
    assign busy_o       = any_v | drain;
    assign clear_o      = clear_i;

`ifdef EXPU_PIPE_CTRL_PERF_CNT_EN
    expu_perf_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_perf_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .op_inc_i    (valid_o & ready_i),
        .stall_inc_i (valid_o & ~ready_i),
        .op_cnt_o    (op_cnt_o),
        .stall_cnt_o (stall_cnt_o)
    );
`else
    assign op_cnt_o    = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

`default_nettype wire
